// File: rtl/bus_xfer_ctrl_if.sv
// Command, strobe and data-bus bundle between the transfer sequencer and its environment.
// Abort/aborted signals exist only when XFER_ABORT_EN is defined.
interface bus_xfer_ctrl_if #(
    parameter int SRAM_AW = 7,
    parameter int FR_AW   = 5,
    parameter int DW      = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [SRAM_AW-1:0] cmd_sram_addr;
    logic [FR_AW-1:0]   cmd_fr_addr;
    logic [SRAM_AW-1:0] cmd_len;
    logic [DW-1:0]      cmd_data;
    logic [DW-1:0]      bus_rdata;
    logic [DW-1:0]      bus_wdata;
    logic               bus_drive;
    logic               sram_cs;
    logic               sram_oe;
    logic               sram_rw;
    logic [SRAM_AW-1:0] sram_addr;
    logic               fr_we;
    logic               fr_re;
    logic [FR_AW-1:0]   fr_addr;
    logic [DW-1:0]      rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
`ifdef XFER_ABORT_EN
    logic               abort;
    logic               aborted;
`endif

    modport master (
`ifdef XFER_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  cmd_valid, cmd_op, cmd_sram_addr, cmd_fr_addr, cmd_len, cmd_data, bus_rdata,
        output cmd_ready, bus_wdata, bus_drive, sram_cs, sram_oe, sram_rw, sram_addr,
               fr_we, fr_re, fr_addr, rd_data, rd_valid, busy, done
    );

    modport slave (
`ifdef XFER_ABORT_EN
        output abort,
        input  aborted,
`endif
        output cmd_valid, cmd_op, cmd_sram_addr, cmd_fr_addr, cmd_len, cmd_data, bus_rdata,
        input  cmd_ready, bus_wdata, bus_drive, sram_cs, sram_oe, sram_rw, sram_addr,
               fr_we, fr_re, fr_addr, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer sequencer for SRAM <-> file register moves, fills and single accesses.
// Define XFER_ABORT_EN to add the abort input / aborted output.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | addresses/write data valid, strobes inactive
// ACCESS | strobes active for one word
// DONE   | done pulse, rd_valid for reads
module bus_xfer_ctrl #(
    parameter int SRAM_AW = 7,
    parameter int FR_AW   = 5,
    parameter int DW      = 32
) (
    input logic          clk,
    input logic          rst,
    bus_xfer_ctrl_if.master bus
);
    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_WR_SRAM = 3'b001;
    localparam logic [2:0] OP_RD_SRAM = 3'b010;
    localparam logic [2:0] OP_WR_FR   = 3'b011;
    localparam logic [2:0] OP_RD_FR   = 3'b100;
    localparam logic [2:0] OP_S2F     = 3'b101;
    localparam logic [2:0] OP_F2S     = 3'b110;
    localparam logic [2:0] OP_FILL    = 3'b111;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [SRAM_AW-1:0] cnt_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [FR_AW-1:0]   fr_addr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW-1:0]      rdata_q;
    logic               accept;
    logic               last_word;
    logic               is_read;
    logic               cmd_block;
    logic               stop_req;

    assign accept    = bus.cmd_valid && (state_q == IDLE);
    assign is_read   = (op_q == OP_RD_SRAM) || (op_q == OP_RD_FR);
    assign cmd_block = (bus.cmd_op == OP_S2F) || (bus.cmd_op == OP_F2S) || (bus.cmd_op == OP_FILL);

`ifdef XFER_ABORT_EN
    logic abort_q;
    // abort seen in SETUP or in ACCESS still lets the current word finish
    assign stop_req    = abort_q || bus.abort;
    assign bus.aborted = (state_q == DONE) && abort_q;
`else
    assign stop_req = 1'b0;
`endif

    assign last_word = (cnt_q == SRAM_AW'(1)) || stop_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.sram_cs   = 1'b1;
        bus.sram_oe   = 1'b1;
        bus.sram_rw   = 1'b1;
        bus.fr_we     = 1'b0;
        bus.fr_re     = 1'b0;
        bus.bus_drive = 1'b0;
        if (state_q == SETUP || state_q == ACCESS)
            bus.bus_drive = (op_q == OP_WR_SRAM) || (op_q == OP_WR_FR) || (op_q == OP_FILL);
        case (state_q)
            IDLE:   if (accept) state_d = (bus.cmd_op == OP_NOP) ? DONE : SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                state_d = last_word ? DONE : SETUP;
                case (op_q)
                    OP_WR_SRAM, OP_FILL: begin bus.sram_cs = 1'b0; bus.sram_rw = 1'b0; end
                    OP_RD_SRAM:          begin bus.sram_cs = 1'b0; bus.sram_oe = 1'b0; end
                    OP_WR_FR:            bus.fr_we = 1'b1;
                    OP_RD_FR:            bus.fr_re = 1'b1;
                    OP_S2F:  begin bus.sram_cs = 1'b0; bus.sram_oe = 1'b0; bus.fr_we = 1'b1; end
                    OP_F2S:  begin bus.fr_re = 1'b1; bus.sram_cs = 1'b0; bus.sram_rw = 1'b0; end
                    default: ;
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= OP_NOP;
            cnt_q       <= '0;
            sram_addr_q <= '0;
            fr_addr_q   <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else if (accept) begin
            op_q        <= bus.cmd_op;
            sram_addr_q <= bus.cmd_sram_addr;
            fr_addr_q   <= bus.cmd_fr_addr;
            wdata_q     <= bus.cmd_data;
            // single-word ops ignore cmd_len; a zero block length still moves one word
            if (cmd_block && bus.cmd_len != '0) cnt_q <= bus.cmd_len;
            else                                cnt_q <= SRAM_AW'(1);
        end else if (state_q == ACCESS) begin
            sram_addr_q <= sram_addr_q + SRAM_AW'(1);
            fr_addr_q   <= fr_addr_q + FR_AW'(1);
            cnt_q       <= cnt_q - SRAM_AW'(1);
            if (op_q == OP_FILL) wdata_q <= wdata_q + DW'(1);
            if (is_read)         rdata_q <= bus.bus_rdata;
        end
    end

`ifdef XFER_ABORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                               abort_q <= 1'b0;
        else if (accept)                                        abort_q <= 1'b0;
        else if ((state_q == SETUP || state_q == ACCESS) && bus.abort) abort_q <= 1'b1;
    end
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.rd_valid  = (state_q == DONE) && is_read;
    assign bus.rd_data   = rdata_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.fr_addr   = fr_addr_q;

    a_no_contention: assert property (@(posedge clk) disable iff (!rst)
        !(bus.bus_drive && (bus.fr_re || !bus.sram_oe)));
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl with behavioural SRAM / file-register models on the shared bus.
// Abort scenario runs only when XFER_ABORT_EN is defined.
module tb_bus_xfer_ctrl;
    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    bus_xfer_ctrl_if bif();
    bus_xfer_ctrl dut (.clk(clk), .rst(rst), .bus(bif));

    logic [31:0] sram_mem [128];
    logic [31:0] fr_mem   [32];

    assign bif.bus_rdata = bif.bus_drive ? bif.bus_wdata :
                           (!bif.sram_cs && !bif.sram_oe) ? sram_mem[bif.sram_addr] :
                           bif.fr_re ? fr_mem[bif.fr_addr] : 32'h0;

    always @(posedge clk) begin
        if (!bif.sram_cs && !bif.sram_rw) sram_mem[bif.sram_addr] <= bif.bus_rdata;
        if (bif.fr_we)                    fr_mem[bif.fr_addr]     <= bif.bus_rdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          r_done_cyc, r_ready_cyc, r_rv_cyc, r_done_cnt, r_abort_cnt;
    int          r_we_cnt, r_swr_cnt, r_strobe_cnt;
    int          contend_cnt = 0;
    logic [5:0]  r_s1, r_s2;
    logic [6:0]  r_rst_snap;
    logic [31:0] r_rdata, r_frseq, r_srseq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [6:0] sa, input logic [4:0] fa,
                           input logic [6:0] len, input logic [31:0] data,
                           input int abort_cyc, input int rst_cyc);
        logic [5:0] snap;
        int w;
        r_done_cyc = 0; r_ready_cyc = 0; r_rv_cyc = 0; r_done_cnt = 0; r_abort_cnt = 0;
        r_we_cnt = 0; r_swr_cnt = 0; r_strobe_cnt = 0;
        r_s1 = '0; r_s2 = '0; r_rst_snap = '0; r_rdata = '0; r_frseq = '0; r_srseq = '0;
        w = 0;
        while (!bif.cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!bif.cmd_ready) chk("ready_wait", 32'(bif.cmd_ready), 32'd1);
        bif.cmd_op = op; bif.cmd_sram_addr = sa; bif.cmd_fr_addr = fa;
        bif.cmd_len = len; bif.cmd_data = data; bif.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // fields must be latched: scramble them right after acceptance
        bif.cmd_valid = 1'b0; bif.cmd_data = ~data; bif.cmd_sram_addr = ~sa;
        bif.cmd_fr_addr = ~fa; bif.cmd_op = 3'b000; bif.cmd_len = 7'd0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
`ifdef XFER_ABORT_EN
            bif.abort = (k == abort_cyc);
`endif
            if (k == rst_cyc) begin
                #1 rst = 1'b0;
                #1 r_rst_snap = {bif.sram_cs, bif.sram_oe, bif.sram_rw, bif.fr_we,
                                 bif.fr_re, bif.bus_drive, bif.busy};
            end
            snap = {bif.sram_cs, bif.sram_oe, bif.sram_rw, bif.fr_we, bif.fr_re, bif.bus_drive};
            if (k == 1) r_s1 = snap;
            if (k == 2) r_s2 = snap;
            if (bif.fr_we) r_we_cnt++;
            if (!bif.sram_cs && !bif.sram_rw) r_swr_cnt++;
            if (!bif.sram_cs || bif.fr_we || bif.fr_re || bif.bus_drive) r_strobe_cnt++;
            if (!bif.sram_cs || bif.fr_we || bif.fr_re) begin
                r_frseq = {r_frseq[23:0], 3'b000, bif.fr_addr};
                r_srseq = {r_srseq[23:0], 1'b0, bif.sram_addr};
            end
            if (bif.bus_drive && (bif.fr_re || !bif.sram_oe)) contend_cnt++;
            if (bif.done) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = k;
`ifdef XFER_ABORT_EN
                if (bif.aborted) r_abort_cnt++;
`endif
            end
            if (bif.rd_valid && r_rv_cyc == 0) begin r_rv_cyc = k; r_rdata = bif.rd_data; end
            if (bif.cmd_ready) begin r_ready_cyc = k; break; end
        end
        if (r_ready_cyc == 0) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_sram_addr = '0;
        bif.cmd_fr_addr = '0; bif.cmd_len = '0; bif.cmd_data = '0;
`ifdef XFER_ABORT_EN
        bif.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'({bif.cmd_ready, bif.sram_cs, bif.sram_oe, bif.sram_rw, bif.fr_we,
                            bif.fr_re, bif.bus_drive, bif.done, bif.rd_valid, bif.busy}),
            32'b1111000000);
        chk("rst_addr", 32'({bif.sram_addr, bif.fr_addr}), 32'd0);
        chk("rst_rdata", bif.rd_data, 32'd0);
        chk("rst_wdata", bif.bus_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single-word SRAM write then read
        run_cmd(3'b001, 7'd5, 5'd0, 7'd9, 32'hDEADBEEF, 0, 0);
        chk("wr_setup_strb", 32'(r_s1), 32'b111001);
        chk("wr_acc_strb", 32'(r_s2), 32'b010001);
        chk("wr_done_cyc", r_done_cyc, 32'd3);
        chk("wr_ready_cyc", r_ready_cyc, 32'd4);
        chk("wr_sram5", sram_mem[5], 32'hDEADBEEF);
        run_cmd(3'b010, 7'd5, 5'd0, 7'd0, 32'h0, 0, 0);
        chk("rd_acc_strb", 32'(r_s2), 32'b001000);
        chk("rd_rv_cyc", r_rv_cyc, 32'd3);
        chk("rd_data", r_rdata, 32'hDEADBEEF);
        chk("rd_ready_cyc", r_ready_cyc, 32'd4);

        // fill, copy to FR, read back
        run_cmd(3'b111, 7'd0, 5'd0, 7'd4, 32'h10, 0, 0);
        chk("fill_done_cyc", r_done_cyc, 32'd9);
        chk("fill_ready_cyc", r_ready_cyc, 32'd10);
        chk("fill_writes", r_swr_cnt, 32'd4);
        chk("fill_rv", r_rv_cyc, 32'd0);
        run_cmd(3'b101, 7'd0, 5'd8, 7'd4, 32'h0, 0, 0);
        chk("s2f_done_cyc", r_done_cyc, 32'd9);
        chk("s2f_we", r_we_cnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            run_cmd(3'b100, 7'd0, 5'(8 + i), 7'd0, 32'h0, 0, 0);
            chk("rdfr_data", r_rdata, 32'h10 + 32'(i));
        end

        // FR -> SRAM with both address wraps
        run_cmd(3'b011, 7'd0, 5'd30, 7'd0, 32'hA0, 0, 0);
        run_cmd(3'b011, 7'd0, 5'd31, 7'd0, 32'hA1, 0, 0);
        run_cmd(3'b011, 7'd0, 5'd0,  7'd0, 32'hA2, 0, 0);
        run_cmd(3'b011, 7'd0, 5'd1,  7'd0, 32'hA3, 0, 0);
        chk("wrfr_31", fr_mem[31], 32'hA1);
        run_cmd(3'b110, 7'd126, 5'd30, 7'd4, 32'h0, 0, 0);
        chk("f2s_frseq", r_frseq, 32'h1E1F0001);
        chk("f2s_srseq", r_srseq, 32'h7E7F0001);
        chk("f2s_done_cyc", r_done_cyc, 32'd9);
        chk("f2s_sram127", sram_mem[127], 32'hA1);
        chk("f2s_sram1", sram_mem[1], 32'hA3);

        // zero length block and NOP
        run_cmd(3'b111, 7'd20, 5'd0, 7'd0, 32'hAA, 0, 0);
        chk("len0_writes", r_swr_cnt, 32'd1);
        chk("len0_done_cyc", r_done_cyc, 32'd3);
        chk("len0_sram20", sram_mem[20], 32'hAA);
        run_cmd(3'b000, 7'd3, 5'd3, 7'd5, 32'h1, 0, 0);
        chk("nop_done_cyc", r_done_cyc, 32'd1);
        chk("nop_ready_cyc", r_ready_cyc, 32'd2);
        chk("nop_strobes", r_strobe_cnt, 32'd0);

        // reset during the third word's ACCESS of a len=8 fill
        run_cmd(3'b111, 7'd40, 5'd0, 7'd8, 32'h100, 0, 6);
        chk("mid_rst_snap", 32'(r_rst_snap), 32'b1110000);
        chk("mid_rst_writes", r_swr_cnt, 32'd2);
        chk("mid_rst_sram41", sram_mem[41], 32'h101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bif.done) r_done_cnt++;
        end
        chk("mid_rst_no_done", r_done_cnt, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(3'b011, 7'd0, 5'd3, 7'd0, 32'h55, 0, 0);
        chk("post_rst_ready", r_ready_cyc, 32'd4);
        chk("post_rst_fr3", fr_mem[3], 32'h55);

`ifdef XFER_ABORT_EN
        run_cmd(3'b101, 7'd0, 5'd16, 7'd6, 32'h0, 3, 0);
        chk("abort_we", r_we_cnt, 32'd2);
        chk("abort_done_cnt", r_done_cnt, 32'd1);
        chk("abort_flag", r_abort_cnt, 32'd1);
        chk("abort_done_cyc", r_done_cyc, 32'd5);
        run_cmd(3'b000, 7'd0, 5'd0, 7'd0, 32'h0, 0, 0);
        chk("abort_clear", r_abort_cnt, 32'd0);
`endif

        chk("contention", contend_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
